// File: rtl/bp_mem_responder.sv
// Single-outstanding block memory endpoint for one CCE: accepts block reads and
// block writebacks, stores blocks in an internal array, and answers after latency_p cycles.
module bp_mem_responder #(
  parameter int paddr_width_p   = 22,
  parameter int block_width_p   = 512,
  parameter int payload_width_p = 16,
  parameter int mem_els_p       = 64,
  parameter int latency_p       = 4
) (
  input  logic                                               clk_i,
  input  logic                                               reset_n_i,

  input  logic [paddr_width_p+payload_width_p-1:0]           mem_cmd_i,
  input  logic                                               mem_cmd_v_i,
  output logic                                               mem_cmd_yumi_o,

  input  logic [block_width_p+payload_width_p+paddr_width_p-1:0] mem_data_cmd_i,
  input  logic                                               mem_data_cmd_v_i,
  output logic                                               mem_data_cmd_yumi_o,

  output logic [payload_width_p+paddr_width_p-1:0]           mem_resp_o,
  output logic                                               mem_resp_v_o,
  input  logic                                               mem_resp_ready_i,

  output logic [block_width_p+payload_width_p+paddr_width_p-1:0] mem_data_resp_o,
  output logic                                               mem_data_resp_v_o,
  input  logic                                               mem_data_resp_ready_i
);

  localparam int offset_w_lp = $clog2(block_width_p / 8);
  localparam int idx_w_lp    = $clog2(mem_els_p);
  localparam int cnt_w_lp    = (latency_p == 0) ? 1 : $clog2(latency_p + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WR,
    WAIT_RD,
    SEND_RESP,
    SEND_DATA
  } state_e;

  state_e                       state_reg, state_next;
  logic [cnt_w_lp-1:0]          cnt_reg, cnt_next;
  logic [paddr_width_p-1:0]     addr_reg;
  logic [payload_width_p-1:0]   payload_reg;
  logic [block_width_p-1:0]     rd_data_reg;

  logic [block_width_p-1:0]     mem_array [mem_els_p];

  logic [paddr_width_p-1:0]     cmd_addr;
  logic [payload_width_p-1:0]   cmd_payload;
  logic [paddr_width_p-1:0]     dcmd_addr;
  logic [payload_width_p-1:0]   dcmd_payload;
  logic [block_width_p-1:0]     dcmd_data;

  logic                         cmd_yumi, dcmd_yumi;
  logic                         cmd_acc, dcmd_acc;
  logic                         rd_en, rd_en_q;
  logic                         wait_expire;
  logic [idx_w_lp-1:0]          rd_idx, wr_idx;

  assign cmd_addr     = mem_cmd_i[paddr_width_p-1:0];
  assign cmd_payload  = mem_cmd_i[paddr_width_p+payload_width_p-1:paddr_width_p];
  assign dcmd_addr    = mem_data_cmd_i[paddr_width_p-1:0];
  assign dcmd_payload = mem_data_cmd_i[paddr_width_p+payload_width_p-1:paddr_width_p];
  assign dcmd_data    = mem_data_cmd_i[block_width_p+payload_width_p+paddr_width_p-1:
                                       paddr_width_p+payload_width_p];

  // Counter holds at zero; a value of 1 (or 0) marks the last wait cycle.
  assign wait_expire = (cnt_reg <= cnt_w_lp'(1));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cmd_yumi   = 1'b0;
    dcmd_yumi  = 1'b0;
    rd_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_data_cmd_v_i) begin
          dcmd_yumi  = 1'b1;
          cnt_next   = cnt_w_lp'(latency_p);
          state_next = (latency_p == 0) ? SEND_RESP : WAIT_WR;
        end else if (mem_cmd_v_i) begin
          cmd_yumi   = 1'b1;
          cnt_next   = cnt_w_lp'(latency_p);
          state_next = (latency_p == 0) ? SEND_DATA : WAIT_RD;
          rd_en      = (latency_p == 0);
        end
      end
      WAIT_WR: begin
        cnt_next = (cnt_reg == '0) ? '0 : cnt_reg - cnt_w_lp'(1);
        if (wait_expire) state_next = SEND_RESP;
      end
      WAIT_RD: begin
        cnt_next = (cnt_reg == '0) ? '0 : cnt_reg - cnt_w_lp'(1);
        rd_en    = wait_expire;
        if (wait_expire) state_next = SEND_DATA;
      end
      SEND_RESP: if (mem_resp_ready_i) state_next = IDLE;
      SEND_DATA: if (mem_data_resp_ready_i) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Gating with the reset pin makes the yumis drop the moment reset asserts.
  assign cmd_acc  = cmd_yumi  & reset_n_i;
  assign dcmd_acc = dcmd_yumi & reset_n_i;
  assign rd_en_q  = rd_en     & reset_n_i;

  assign mem_cmd_yumi_o      = cmd_acc;
  assign mem_data_cmd_yumi_o = dcmd_acc;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      payload_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (dcmd_acc) begin
        addr_reg    <= dcmd_addr;
        payload_reg <= dcmd_payload;
      end else if (cmd_acc) begin
        addr_reg    <= cmd_addr;
        payload_reg <= cmd_payload;
      end
    end
  end

  // With zero latency the read samples on the accept edge, so it uses the live address.
  assign rd_idx = (state_reg == IDLE) ? cmd_addr[offset_w_lp +: idx_w_lp]
                                      : addr_reg[offset_w_lp +: idx_w_lp];
  assign wr_idx = dcmd_addr[offset_w_lp +: idx_w_lp];

  always_ff @(posedge clk_i) begin
    if (dcmd_acc) mem_array[wr_idx] <= dcmd_data;
    if (rd_en_q)  rd_data_reg       <= mem_array[rd_idx];
  end

  assign mem_resp_v_o      = (state_reg == SEND_RESP);
  assign mem_data_resp_v_o = (state_reg == SEND_DATA);
  assign mem_resp_o        = {payload_reg, addr_reg};
  assign mem_data_resp_o   = {rd_data_reg, payload_reg, addr_reg};

endmodule
